text_scan_reader: RTL and testbench
===================================

Name: text_scan_reader

Overview:
- Reader end of the text screen buffer. The buffer filler writes character codes into the buffer by (x, y) cell; this block reads them back in raster order, locked to the XGA pixel stream.
- For every active pixel it drives the buffer read address. It then emits the character code together with the glyph row and column, aligned to a valid strobe, for the font ROM and pixel stage.
- It pulses `refresh` once per frame so the filler can start its next frame.

Parameters:
- width, 128: character cells per text row (1024 / glyph_w).
- height, 48: text rows per frame (768 / glyph_h).
- char_width, 8: character code width in bits.
- glyph_w, 8: pixels per glyph column; must be a power of two.
- glyph_h, 16: pixel lines per glyph; must be a power of two.
- rd_latency, 1: buffer read latency in cycles, 1..4.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous reset, active-low; asserted when 0.
- frame_start  in  1  one-cycle pulse at the first active pixel of a frame.
- active  in  1  high during active video pixels.
- rd_en  out  1  buffer read enable.
- rd_x  out  log2(width)  buffer read column.
- rd_y  out  log2(height)  buffer read row.
- rd_data  in  char_width  buffer read data, valid rd_latency cycles after rd_en.
- char_out  out  char_width  character code for the current pixel.
- glyph_row  out  log2(glyph_h)  scanline within the glyph.
- glyph_col  out  log2(glyph_w)  pixel within the glyph.
- valid  out  1  char_out, glyph_row and glyph_col are valid.
- refresh  out  1  one-cycle end-of-frame pulse to the filler.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs go to 0 and all counters clear.
  - FSM state becomes IDLE.
  - The pipeline is flushed; valid stays 0 until the first frame_start after release.
- FSM states:
  - IDLE: wait for frame_start; frame_start moves to SCAN.
  - SCAN: on active = 1, advance the counters. On active = 0, hold the counters and assert nothing.
  - FLUSH: the last pixel of the frame has been issued; drain rd_latency cycles.
  - DONE: assert refresh = 1 for exactly one cycle, then go to IDLE.
- Counters (all change only on active pixels in SCAN):
  - col_px counts 0..glyph_w-1. On wrap, cell_x increments.
  - cell_x counts 0..width-1. On wrap, row_px increments and cell_x returns to 0.
  - row_px counts 0..glyph_h-1. On wrap, cell_y increments.
  - cell_y counts 0..height-1. After cell_y = height-1, row_px = glyph_h-1, cell_x = width-1, col_px = glyph_w-1, go to FLUSH.
- Read issue:
  - rd_en = 1 only on active cycles in SCAN with col_px = 0, i.e. one read per cell per scanline.
  - rd_x = cell_x and rd_y = cell_y on those cycles, and are registered outputs.
  - Between reads, rd_x and rd_y hold their last values.
- Output alignment:
  - glyph_row, glyph_col and valid go through a rd_latency-deep shift register.
  - rd_data is captured when the delayed read strobe fires and is held for the remaining glyph_w-1 pixels of the cell.
  - Total latency from active to valid is rd_latency + 1 cycles.
- frame_start in SCAN or FLUSH: abort the frame and restart all counters from 0. The pipeline flushes, so valid drops for the in-flight entries. refresh is not pulsed.
- Gaps in active (blanking) stall the counters and the pipeline input only. In-flight pipeline entries still drain.
- Extra active pixels after FLUSH are ignored.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- When defined, the block adds these ports:
  - cursor_x in, log2(width): cursor column.
  - cursor_y in, log2(height): cursor row.
  - cursor_on out, 1: cursor overlay for the current pixel.
- Blink timing:
  - A frame counter toggles a blink phase every 32 frames, counted on refresh.
  - cursor_on = 1 when all of the following hold: the output cell equals (cursor_x, cursor_y), glyph_row ≥ glyph_h-2, and the blink phase is 1.
  - cursor_on is aligned with valid.
- When the macro is undefined, the ports and the frame counter do not exist.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, SCAN, FLUSH, DONE).
  - Default XGA text geometry constants: 128x48 cells, 8x16 glyph.
  - Blink period constant, 32.
- Sub-module scan_pipe:
  - Parameterised delay line of depth rd_latency.
  - Carries valid, glyph_row, glyph_col and the cell coordinates.
  - Has the same asynchronous active-low reset and a synchronous flush input.

Test Plan:
- Reset low for 3 cycles mid-frame, then high: all outputs are 0, and valid stays 0 until frame_start.
- frame_start, then a continuous active stream with a buffer model returning code = (x + y) mod 62 + 48:
  - First valid appears 2 cycles after the first active pixel, with char_out = 48, glyph_row = 0, glyph_col = 0.
  - rd_en fires once every 8 active pixels.
- Blank active for 160 cycles after each 1024-pixel line:
  - Counters hold during the gap.
  - Line 16 reads rd_y = 1 with rd_x restarting at 0.
- Full frame of 1024x768 active pixels:
  - Exactly 128*48*16 = 98304 rd_en pulses.
  - refresh pulses once, rd_latency + 1 cycles after the last active pixel.
- frame_start asserted at cell (5, 3): counters restart at (0, 0), and no refresh pulse occurs.
- With TEXT_CURSOR_EN, cursor_x = 10, cursor_y = 2, 64 frames:
  - cursor_on is high only in cell (10, 2), glyph_row 14..15.
  - It is asserted during frames 32..63 and low during frames 0..31.

Source files
------------

// File: rtl/text_scan_reader_pkg.sv
// ============================================================================
// Module   : text_scan_reader_pkg
// Purpose  : Shared FSM encoding, XGA text geometry and a width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package text_scan_reader_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SCAN  = 2'd1;
   localparam state_t ST_FLUSH = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam int XGA_TEXT_COLS = 128;
   localparam int XGA_TEXT_ROWS = 48;
   localparam int XGA_GLYPH_W   = 8;
   localparam int XGA_GLYPH_H   = 16;
   localparam int BLINK_PERIOD  = 32;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/text_scan_reader_scan_pipe.sv
// ============================================================================
// Module   : text_scan_reader_scan_pipe
// Purpose  : Delay line matching the buffer read latency for pixel tags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_scan_reader_scan_pipe #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/text_scan_reader.sv
// ============================================================================
// Module   : text_scan_reader
// Purpose  : Raster-order text buffer reader locked to the pixel stream.
//            Optional cursor overlay enabled by defining TEXT_CURSOR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_scan_reader
   import text_scan_reader_pkg::*;
#(
   parameter int WIDTH      = XGA_TEXT_COLS,
   parameter int HEIGHT     = XGA_TEXT_ROWS,
   parameter int CHAR_WIDTH = 8,
   parameter int GLYPH_W    = XGA_GLYPH_W,
   parameter int GLYPH_H    = XGA_GLYPH_H,
   parameter int RD_LATENCY = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_start,
   input  logic                           active,
   output logic                           rd_en,
   output logic [clog2_min1(WIDTH)-1:0]   rd_x,
   output logic [clog2_min1(HEIGHT)-1:0]  rd_y,
   input  logic [CHAR_WIDTH-1:0]          rd_data,
   output logic [CHAR_WIDTH-1:0]          char_out,
   output logic [clog2_min1(GLYPH_H)-1:0] glyph_row,
   output logic [clog2_min1(GLYPH_W)-1:0] glyph_col,
   output logic                           valid,
   output logic                           refresh
`ifdef TEXT_CURSOR_EN
   ,
   input  logic [clog2_min1(WIDTH)-1:0]   cursor_x,
   input  logic [clog2_min1(HEIGHT)-1:0]  cursor_y,
   output logic                           cursor_on
`endif
);

   localparam int XW = clog2_min1(WIDTH);
   localparam int YW = clog2_min1(HEIGHT);
   localparam int RW = clog2_min1(GLYPH_H);
   localparam int CW = clog2_min1(GLYPH_W);
`ifdef TEXT_CURSOR_EN
   localparam int PW = 2 + RW + CW + XW + YW;
`else
   localparam int PW = 2 + RW + CW;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   col_px_q, col_px_d;
   logic [XW-1:0]   cell_x_q, cell_x_d;
   logic [RW-1:0]   row_px_q, row_px_d;
   logic [YW-1:0]   cell_y_q, cell_y_d;
   logic [1:0]      flush_cnt_q, flush_cnt_d;

   logic [CW-1:0]   w_col_px;
   logic [XW-1:0]   w_cell_x;
   logic [RW-1:0]   w_row_px;
   logic [YW-1:0]   w_cell_y;
   logic            w_col_wrap, w_x_wrap, w_row_wrap, w_last;
   logic            w_pix, w_issue;

   logic            rd_en_q;
   logic [XW-1:0]   rd_x_q;
   logic [YW-1:0]   rd_y_q;
   logic            iss_vld_q;
   logic [RW-1:0]   iss_row_q;
   logic [CW-1:0]   iss_col_q;
   logic [CHAR_WIDTH-1:0] char_q;

   logic [PW-1:0]   w_pipe_in, w_pipe_out;
   logic            w_out_vld, w_out_rd;

   // A frame_start pixel is pixel (0,0) of the new frame, whatever the old counters held.
   assign w_col_px   = frame_start ? '0 : col_px_q;
   assign w_cell_x   = frame_start ? '0 : cell_x_q;
   assign w_row_px   = frame_start ? '0 : row_px_q;
   assign w_cell_y   = frame_start ? '0 : cell_y_q;
   assign w_col_wrap = (w_col_px == CW'(GLYPH_W - 1));
   assign w_x_wrap   = (w_cell_x == XW'(WIDTH - 1));
   assign w_row_wrap = (w_row_px == RW'(GLYPH_H - 1));
   assign w_last     = w_col_wrap && w_x_wrap && w_row_wrap &&
                       (w_cell_y == YW'(HEIGHT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = (w_pix && w_last) ? ST_FLUSH : ST_SCAN;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_SCAN:  if (w_pix && w_last) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_cnt_q == 2'(RD_LATENCY - 1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_pix   = active && (frame_start || (state_q == ST_SCAN));
      w_issue = w_pix && (w_col_px == '0);
      refresh = (state_q == ST_DONE);
   end

   always_comb begin
      col_px_d    = w_col_px;
      cell_x_d    = w_cell_x;
      row_px_d    = w_row_px;
      cell_y_d    = w_cell_y;
      flush_cnt_d = ((state_q == ST_FLUSH) && !frame_start) ? flush_cnt_q + 2'd1 : 2'd0;
      if (w_pix) begin
         if (w_last) begin
            col_px_d = '0;
            cell_x_d = '0;
            row_px_d = '0;
            cell_y_d = '0;
         end else begin
            col_px_d = w_col_wrap ? '0 : w_col_px + CW'(1);
            if (w_col_wrap) begin
               cell_x_d = w_x_wrap ? '0 : w_cell_x + XW'(1);
               if (w_x_wrap) begin
                  row_px_d = w_row_wrap ? '0 : w_row_px + RW'(1);
                  if (w_row_wrap) cell_y_d = w_cell_y + YW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_px_q    <= '0;
         cell_x_q    <= '0;
         row_px_q    <= '0;
         cell_y_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         col_px_q    <= col_px_d;
         cell_x_q    <= cell_x_d;
         row_px_q    <= row_px_d;
         cell_y_q    <= cell_y_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Issue stage: rd_x/rd_y hold the current cell, so they double as the pixel's cell tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_en_q   <= 1'b0;
         rd_x_q    <= '0;
         rd_y_q    <= '0;
         iss_vld_q <= 1'b0;
         iss_row_q <= '0;
         iss_col_q <= '0;
      end else begin
         rd_en_q   <= w_issue;
         iss_vld_q <= w_pix;
         if (w_issue) begin
            rd_x_q <= w_cell_x;
            rd_y_q <= w_cell_y;
         end
         if (w_pix) begin
            iss_row_q <= w_row_px;
            iss_col_q <= w_col_px;
         end
      end
   end

   assign rd_en = rd_en_q;
   assign rd_x  = rd_x_q;
   assign rd_y  = rd_y_q;

`ifdef TEXT_CURSOR_EN
   logic [XW-1:0] w_out_x;
   logic [YW-1:0] w_out_y;
   assign w_pipe_in = {iss_vld_q, rd_en_q, iss_row_q, iss_col_q, rd_x_q, rd_y_q};
   assign {w_out_vld, w_out_rd, glyph_row, glyph_col, w_out_x, w_out_y} = w_pipe_out;
`else
   assign w_pipe_in = {iss_vld_q, rd_en_q, iss_row_q, iss_col_q};
   assign {w_out_vld, w_out_rd, glyph_row, glyph_col} = w_pipe_out;
`endif

   text_scan_reader_scan_pipe #(
      .DW    (PW),
      .DEPTH (RD_LATENCY)
   ) u_scan_pipe (
      .clk   (clk),
      .reset (reset),
      .flush (frame_start),
      .d     (w_pipe_in),
      .q     (w_pipe_out)
   );

   assign valid = w_out_vld;

   // Read data is only valid on the strobe cycle; hold it for the rest of the cell.
   always_comb begin
      char_out = (w_out_vld && w_out_rd) ? rd_data : char_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) char_q <= '0;
      else        char_q <= char_out;
   end

`ifdef TEXT_CURSOR_EN
   localparam int BW = clog2_min1(BLINK_PERIOD);
   logic [BW-1:0] blink_cnt_q;
   logic          blink_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else if (refresh) begin
         blink_cnt_q <= blink_cnt_q + BW'(1);
         if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) blink_q <= ~blink_q;
      end
   end

   assign cursor_on = w_out_vld && blink_q &&
                      (w_out_x == cursor_x) && (w_out_y == cursor_y) &&
                      (glyph_row >= RW'(GLYPH_H - 2));
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_scan_reader.sv
// ============================================================================
// Module   : tb_text_scan_reader
// Purpose  : Scoreboard bench for text_scan_reader on a reduced geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_text_scan_reader;

   localparam int W  = 16;
   localparam int H  = 4;
   localparam int GW = 4;
   localparam int GH = 4;
   localparam int L  = 1;
   localparam int CUR_X = 10;
   localparam int CUR_Y = 2;

   typedef struct {
      int tag;
      int row;
      int col;
      int ch;
      int cur;
   } px_t;

   typedef struct {
      int tag;
      int x;
      int y;
   } rd_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic       active;
   logic       rd_en;
   logic [3:0] rd_x;
   logic [1:0] rd_y;
   logic [7:0] rd_data;
   logic [7:0] char_out;
   logic [1:0] glyph_row;
   logic [1:0] glyph_col;
   logic       valid;
   logic       refresh;
`ifdef TEXT_CURSOR_EN
   logic [3:0] cursor_x;
   logic [1:0] cursor_y;
   logic       cursor_on;
`endif

   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  rd_count = 0;
   int  refresh_count = 0;
   int  nframes = 0;
   int  last_rx = 0;
   int  last_ry = 0;
   px_t pq[$];
   rd_t rq[$];
   int  fq[$];
   px_t ce;
   rd_t cr;
   int  cf;
   logic [7:0] mem_q [L];

   text_scan_reader #(
      .WIDTH      (W),
      .HEIGHT     (H),
      .CHAR_WIDTH (8),
      .GLYPH_W    (GW),
      .GLYPH_H    (GH),
      .RD_LATENCY (L)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .active      (active),
      .rd_en       (rd_en),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_data     (rd_data),
      .char_out    (char_out),
      .glyph_row   (glyph_row),
      .glyph_col   (glyph_col),
      .valid       (valid),
      .refresh     (refresh)
`ifdef TEXT_CURSOR_EN
      ,
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .cursor_on   (cursor_on)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic int code(input int x, input int y);
      return (x + y) % 62 + 48;
   endfunction

   // Buffer model: data for the sampled address appears L cycles later.
   always @(posedge clk) begin
      mem_q[0] <= rd_en ? 8'(code(int'(rd_x), int'(rd_y))) : 8'hEE;
      for (int i = 1; i < L; i++) mem_q[i] <= mem_q[i-1];
   end
   assign rd_data = mem_q[L-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         if (fails <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (valid) begin
            if (pq.size() == 0) chk("spurious_valid", 32'(valid), 0);
            else begin
               ce = pq.pop_front();
               chk("valid_cycle", cyc, ce.tag);
               chk("glyph_row", 32'(glyph_row), ce.row);
               chk("glyph_col", 32'(glyph_col), ce.col);
               chk("char_out", 32'(char_out), ce.ch);
`ifdef TEXT_CURSOR_EN
               chk("cursor_on", 32'(cursor_on), ce.cur);
`endif
            end
         end else begin
`ifdef TEXT_CURSOR_EN
            chk("cursor_idle", 32'(cursor_on), 0);
`endif
            if (pq.size() > 0 && pq[0].tag <= cyc) begin
               chk("valid_present", 32'(valid), 1);
               void'(pq.pop_front());
            end
         end
         if (rd_en) begin
            rd_count++;
            if (rq.size() == 0) chk("spurious_rd_en", 32'(rd_en), 0);
            else begin
               cr = rq.pop_front();
               chk("rd_cycle", cyc, cr.tag);
               chk("rd_x", 32'(rd_x), cr.x);
               chk("rd_y", 32'(rd_y), cr.y);
               last_rx = cr.x;
               last_ry = cr.y;
            end
         end else begin
            chk("rd_x_hold", 32'(rd_x), last_rx);
            chk("rd_y_hold", 32'(rd_y), last_ry);
            if (rq.size() > 0 && rq[0].tag <= cyc) begin
               chk("rd_en_present", 32'(rd_en), 1);
               void'(rq.pop_front());
            end
         end
         if (refresh) begin
            refresh_count++;
            if (fq.size() == 0) chk("spurious_refresh", 32'(refresh), 0);
            else begin
               cf = fq.pop_front();
               chk("refresh_cycle", cyc, cf);
            end
         end else if (fq.size() > 0 && fq[0] <= cyc) begin
            chk("refresh_present", 32'(refresh), 1);
            void'(fq.pop_front());
         end
      end
   end

   task automatic idle_cycles(input int n, input logic act);
      repeat (n) begin
         @(negedge clk);
         frame_start = 1'b0;
         active      = act;
      end
   endtask

   task automatic drive_px(input bit fs, input int x, input int y, input int r, input int c);
      px_t e;
      @(negedge clk);
      frame_start = fs;
      active      = 1'b1;
      // An abort drops every pixel that has not yet reached the output.
      if (fs) while (pq.size() > 0 && pq[$].tag > cyc) void'(pq.pop_back());
      e.tag = cyc + 1 + L;
      e.row = r;
      e.col = c;
      e.ch  = code(x, y);
      e.cur = (x == CUR_X && y == CUR_Y && r >= GH - 2 && ((nframes / 32) % 2) == 1) ? 1 : 0;
      pq.push_back(e);
      if (c == 0) rq.push_back('{tag: cyc + 1, x: x, y: y});
      if (x == W - 1 && y == H - 1 && r == GH - 1 && c == GW - 1) fq.push_back(cyc + 1 + L);
   endtask

   task automatic drive_frame(input int stop_px, input int gap);
      int idx;
      idx = 0;
      for (int y = 0; y < H; y++) begin
         for (int r = 0; r < GH; r++) begin
            for (int x = 0; x < W; x++) begin
               for (int c = 0; c < GW; c++) begin
                  if (idx == stop_px) return;
                  drive_px(idx == 0, x, y, r, c);
                  idx++;
               end
            end
            if (gap > 0) idle_cycles(gap, 1'b0);
         end
      end
      nframes++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      int fsnap;
      reset       = 1'b0;
      frame_start = 1'b0;
      active      = 1'b0;
`ifdef TEXT_CURSOR_EN
      cursor_x    = 4'(CUR_X);
      cursor_y    = 2'(CUR_Y);
`endif
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_x", 32'(rd_x), 0);
      chk("rst_rd_y", 32'(rd_y), 0);
      chk("rst_char_out", 32'(char_out), 0);
      chk("rst_glyph_row", 32'(glyph_row), 0);
      chk("rst_glyph_col", 32'(glyph_col), 0);
      chk("rst_refresh", 32'(refresh), 0);
`ifdef TEXT_CURSOR_EN
      chk("rst_cursor_on", 32'(cursor_on), 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      idle_cycles(2, 1'b0);

      // Partial frame interrupted by a 3-cycle reset.
      drive_frame(150, 0);
      @(negedge clk);
      reset = 1'b0;
      pq.delete();
      rq.delete();
      fq.delete();
      last_rx = 0;
      last_ry = 0;
      nframes = 0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_valid", 32'(valid), 0);
         chk("midrst_rd_en", 32'(rd_en), 0);
         chk("midrst_char_out", 32'(char_out), 0);
         chk("midrst_rd_x", 32'(rd_x), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      snap  = rd_count;
      idle_cycles(20, 1'b1);
      chk("no_read_before_fs", rd_count - snap, 0);

      // Full frame with blanking after every pixel line, then stray active pixels.
      snap  = rd_count;
      fsnap = refresh_count;
      drive_frame(-1, 20);
      idle_cycles(8, 1'b1);
      chk("frame_rd_count", rd_count - snap, W * H * GH);
      chk("frame_refresh_count", refresh_count - fsnap, 1);

      // Abort at cell (5,3), then a complete frame.
      fsnap = refresh_count;
      drive_frame(((3 * GH + 1) * W + 5) * GW + 2, 0);
      drive_frame(-1, 0);
      idle_cycles(8, 1'b0);
      chk("abort_refresh_count", refresh_count - fsnap, 1);

      snap = rd_count;
      drive_frame(-1, 0);
      idle_cycles(8, 1'b0);
      chk("frame2_rd_count", rd_count - snap, W * H * GH);

`ifdef TEXT_CURSOR_EN
      while (nframes < 64) begin
         drive_frame(-1, 0);
         idle_cycles(4, 1'b0);
      end
`endif

      idle_cycles(6, 1'b0);
      chk("pix_queue_drained", pq.size(), 0);
      chk("rd_queue_drained", rq.size(), 0);
      chk("refresh_queue_drained", fq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
